// File: rtl/pp_result_drain_if.sv
// rtl/pp_result_drain_if.sv - row input / element output stream bundle for pp_result_drain
// Purpose: groups the fill-side row stream, the drain-side element stream and the
//          sticky length-error flag of pp_result_drain.
// Signals: in_valid/in_ready/in_data/in_last  row stream from the matmul array
//          out_valid/out_ready/out_data/out_last element stream to the consumer
//          len_err                              sticky overlong-tile flag
// Modports: slave = drain block side, master = producer/consumer side.
interface pp_result_drain_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*WIDTH-1:0]   in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_last;
  logic                     len_err;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, len_err
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, len_err
  );
endinterface

// File: rtl/pp_result_drain.sv
// rtl/pp_result_drain.sv - ping-pong result tile capture and per-element serialiser
// Purpose: captures result rows from the systolic array into two alternating banks
//          and drains each finished tile one element per beat, row-major, lane 0 first.
// Ports:   clk, rst (synchronous, active-high)
//          bus (pp_result_drain_if.slave): in_* row stream, out_* element stream, len_err
//          tiles_drained[15:0] (only when PP_DRAIN_STATS_EN is defined)
// Option:  PP_DRAIN_STATS_EN adds a wrapping count of completed output tiles.
module pp_result_drain #(
  parameter int WIDTH     = 16,
  parameter int LANES     = 4,
  parameter int TILE_ROWS = 8
) (
  input  logic                clk,
  input  logic                rst,
  pp_result_drain_if.slave    bus
`ifdef PP_DRAIN_STATS_EN
  ,
  output logic [15:0]         tiles_drained
`endif
);

  localparam int RW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
  localparam int LW = $clog2(TILE_ROWS + 1);
  localparam int NW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                 state, state_next;
  logic [LANES*WIDTH-1:0] mem [2][TILE_ROWS];
  logic [1:0]             full;
  logic [LW-1:0]          len [2];
  logic                   fill_sel, drain_sel;
  logic [RW-1:0]          wr_row, rd_row;
  logic [NW-1:0]          rd_lane;
  logic                   len_err_q;

  logic                   in_fire, row_limit, close;
  logic                   out_fire, release_bank, at_last;
  logic                   out_valid_c, out_last_c;
  logic [WIDTH-1:0]       out_data_c, elem;
  logic [LANES*WIDTH-1:0] rd_word;

  // ---------------- fill side ----------------
  assign bus.in_ready = !full[fill_sel];
  assign in_fire      = bus.in_valid && !full[fill_sel];
  assign row_limit    = (wr_row == RW'(TILE_ROWS - 1));
  // A tile closes on its last row, or forcibly when the bank runs out of rows.
  assign close        = in_fire && (bus.in_last || row_limit);
  assign bus.len_err  = len_err_q;

  always_ff @(posedge clk) begin
    if (in_fire) mem[fill_sel][wr_row] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_sel  <= 1'b0;
      wr_row    <= '0;
      len_err_q <= 1'b0;
      len[0]    <= '0;
      len[1]    <= '0;
    end else if (in_fire) begin
      if (close) begin
        wr_row        <= '0;
        fill_sel      <= ~fill_sel;
        len[fill_sel] <= LW'(wr_row) + LW'(1);
        if (!bus.in_last) len_err_q <= 1'b1;
      end else begin
        wr_row <= wr_row + RW'(1);
      end
    end
  end

  // Fill only ever closes an empty bank and drain only releases a full one,
  // so the two updates never target the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (close)        full[fill_sel]  <= 1'b1;
      if (release_bank) full[drain_sel] <= 1'b0;
    end
  end

  // ---------------- drain side ----------------
  assign rd_word = mem[drain_sel][rd_row];

  always_comb begin
    elem = '0;
    for (int j = 0; j < LANES; j++) begin
      if (rd_lane == NW'(j)) elem = rd_word[j*WIDTH +: WIDTH];
    end
  end

  assign at_last = (LW'(rd_row) == len[drain_sel] - LW'(1)) &&
                   (rd_lane == NW'(LANES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    out_valid_c  = 1'b0;
    out_last_c   = 1'b0;
    out_data_c   = '0;
    out_fire     = 1'b0;
    release_bank = 1'b0;
    case (state)
      IDLE: begin
        if (full[drain_sel]) state_next = DRAIN;
      end
      DRAIN: begin
        out_valid_c = 1'b1;
        out_data_c  = elem;
        out_last_c  = at_last;
        out_fire    = bus.out_ready;
        if (bus.out_ready && at_last) begin
          release_bank = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.out_data  = out_data_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_row    <= '0;
      rd_lane   <= '0;
      drain_sel <= 1'b0;
    end else begin
      if (state == IDLE) begin
        rd_row  <= '0;
        rd_lane <= '0;
      end else if (out_fire) begin
        if (rd_lane == NW'(LANES - 1)) begin
          rd_lane <= '0;
          rd_row  <= rd_row + RW'(1);
        end else begin
          rd_lane <= rd_lane + NW'(1);
        end
      end
      if (release_bank) drain_sel <= ~drain_sel;
    end
  end

`ifdef PP_DRAIN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)               tiles_drained <= 16'd0;
    else if (release_bank) tiles_drained <= tiles_drained + 16'd1;
  end
`endif

endmodule
